// File: rtl/regfile_mp_if.sv
// Port bundle for the multi-port register file: read/write ports, reserve request,
// scoreboard and debug views. The master drives requests; the slave is the register file.
interface regfile_mp_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 2
);
  localparam int AW = $clog2(NREG);

  logic [NRD-1:0]       rd_en;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_busy;
  logic [NWR-1:0]       wr_en;
  logic [NWR*AW-1:0]    wr_addr;
  logic [NWR*XLEN-1:0]  wr_data;
  logic                 rsv_en;
  logic [AW-1:0]        rsv_addr;
  logic [NREG-1:0]      busy;
  logic [NREG*XLEN-1:0] dbg_regs;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_busy, busy, dbg_regs
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_busy, busy, dbg_regs
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with registered, write-forwarded reads and a per-register
// busy scoreboard. Register 0 reads as zero; the stack pointer resets to SP_INIT.
module regfile_mp #(
  parameter int               XLEN    = 32,
  parameter int               NREG    = 32,
  parameter int               NRD     = 2,
  parameter int               NWR     = 2,
  parameter int               SP_IDX  = 2,
  parameter logic [XLEN-1:0]  SP_INIT = 32'd512
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);
  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0]           regs [NREG];
  logic [NREG-1:0]           busy_q;
  logic [NREG-1:0]           clr_mask;
  logic [NREG-1:0]           rsv_mask;
  logic [NREG-1:0]           busy_after_clr;
  logic [NRD-1:0][XLEN-1:0]  rd_next;
  logic [NRD-1:0]            rd_busy_next;
  logic [NRD-1:0][XLEN-1:0]  rd_data_q;
  logic [NRD-1:0]            rd_busy_q;

  // A retiring write clears its bit; a same-cycle reserve re-sets it afterwards.
  always_comb begin
    clr_mask = '0;
    rsv_mask = '0;
    for (int w = 0; w < NWR; w++) begin
      if (bus.wr_en[w]) clr_mask[bus.wr_addr[w*AW +: AW]] = 1'b1;
    end
    if (bus.rsv_en && bus.rsv_addr != '0) rsv_mask[bus.rsv_addr] = 1'b1;
    busy_after_clr = busy_q & ~clr_mask;
  end

  // Read data sees the array after this cycle's writes, so later ports override earlier ones.
  always_comb begin
    for (int k = 0; k < NRD; k++) begin
      rd_next[k]      = regs[bus.rd_addr[k*AW +: AW]];
      rd_busy_next[k] = busy_after_clr[bus.rd_addr[k*AW +: AW]];
      for (int w = 0; w < NWR; w++) begin
        if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] == bus.rd_addr[k*AW +: AW]
            && bus.rd_addr[k*AW +: AW] != '0)
          rd_next[k] = bus.wr_data[w*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
      busy_q    <= '0;
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] != '0)
          regs[bus.wr_addr[w*AW +: AW]] <= bus.wr_data[w*XLEN +: XLEN];
      end
      busy_q <= busy_after_clr | rsv_mask;
      for (int k = 0; k < NRD; k++) begin
        if (bus.rd_en[k]) begin
          rd_data_q[k] <= rd_next[k];
          rd_busy_q[k] <= rd_busy_next[k];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREG; i++) bus.dbg_regs[i*XLEN +: XLEN] = regs[i];
  end

  assign bus.rd_data = rd_data_q;
  assign bus.rd_busy = rd_busy_q;
  assign bus.busy    = busy_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios followed by random traffic,
// all compared against an array-based reference model of the register file.
module tb_regfile_mp;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) bus ();

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .SP_IDX(2), .SP_INIT(32'd512)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [XLEN-1:0] m_regs [NREG];
  logic [NREG-1:0] m_busy;
  logic [XLEN-1:0] m_rd_data [NRD];
  logic            m_rd_busy [NRD];

  logic            s_rst;
  logic [NRD-1:0]  s_rd_en;
  logic [AW-1:0]   s_rd_addr [NRD];
  logic [NWR-1:0]  s_wr_en;
  logic [AW-1:0]   s_wr_addr [NWR];
  logic [XLEN-1:0] s_wr_data [NWR];
  logic            s_rsv_en;
  logic [AW-1:0]   s_rsv_addr;

  int n_checks = 0;
  int n_fails  = 0;

  task check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task clear_stimulus();
    s_rst = 1'b0; s_rd_en = '0; s_wr_en = '0; s_rsv_en = 1'b0; s_rsv_addr = '0;
    for (int k = 0; k < NRD; k++) s_rd_addr[k] = '0;
    for (int w = 0; w < NWR; w++) begin
      s_wr_addr[w] = '0;
      s_wr_data[w] = '0;
    end
  endtask

  // Drive one cycle, advance the model by the architectural rules, then compare everything.
  task apply_stimulus();
    logic [NREG-1:0] clr;
    @(negedge clk);
    rst = s_rst;
    bus.rd_en = s_rd_en;
    bus.wr_en = s_wr_en;
    bus.rsv_en = s_rsv_en;
    bus.rsv_addr = s_rsv_addr;
    for (int k = 0; k < NRD; k++) bus.rd_addr[k*AW +: AW] = s_rd_addr[k];
    for (int w = 0; w < NWR; w++) begin
      bus.wr_addr[w*AW +: AW]     = s_wr_addr[w];
      bus.wr_data[w*XLEN +: XLEN] = s_wr_data[w];
    end
    @(posedge clk);
    #1;
    if (s_rst) begin
      for (int i = 0; i < NREG; i++) m_regs[i] = (i == 2) ? 32'd512 : 32'd0;
      m_busy = '0;
      for (int k = 0; k < NRD; k++) begin
        m_rd_data[k] = '0;
        m_rd_busy[k] = 1'b0;
      end
    end else begin
      clr = '0;
      for (int w = 0; w < NWR; w++) begin
        if (s_wr_en[w]) begin
          clr[s_wr_addr[w]] = 1'b1;
          if (s_wr_addr[w] != 0) m_regs[s_wr_addr[w]] = s_wr_data[w];
        end
      end
      for (int k = 0; k < NRD; k++) begin
        if (s_rd_en[k]) begin
          m_rd_data[k] = m_regs[s_rd_addr[k]];
          m_rd_busy[k] = m_busy[s_rd_addr[k]] & ~clr[s_rd_addr[k]];
        end
      end
      m_busy = m_busy & ~clr;
      if (s_rsv_en && s_rsv_addr != 0) m_busy[s_rsv_addr] = 1'b1;
    end
    for (int k = 0; k < NRD; k++) begin
      check_output($sformatf("rd_data[%0d]", k), bus.rd_data[k*XLEN +: XLEN], m_rd_data[k]);
      check_output($sformatf("rd_busy[%0d]", k), bus.rd_busy[k], m_rd_busy[k]);
    end
    check_output("busy", bus.busy, m_busy);
    for (int i = 0; i < NREG; i++)
      check_output($sformatf("dbg_regs[%0d]", i), bus.dbg_regs[i*XLEN +: XLEN], m_regs[i]);
  endtask

  initial begin
    rst = 1'b1;
    bus.rd_en = '0; bus.rd_addr = '0; bus.wr_en = '0; bus.wr_addr = '0;
    bus.wr_data = '0; bus.rsv_en = 1'b0; bus.rsv_addr = '0;
    clear_stimulus();

    $display("[TB] reset values");
    s_rst = 1'b1;
    apply_stimulus();
    clear_stimulus();
    s_rd_en = 2'b11; s_rd_addr[0] = 5'd2; s_rd_addr[1] = 5'd5;
    apply_stimulus();
    check_output("t1_sp", bus.rd_data[31:0], 64'd512);
    check_output("t1_x5", bus.rd_data[63:32], 64'd0);
    check_output("t1_busy", bus.busy, 64'd0);
    check_output("t1_dbg2", bus.dbg_regs[2*XLEN +: XLEN], 64'd512);

    $display("[TB] forwarding");
    clear_stimulus();
    s_wr_en = 2'b01; s_wr_addr[0] = 5'd7; s_wr_data[0] = 32'hDEADBEEF;
    s_rd_en = 2'b11; s_rd_addr[0] = 5'd7; s_rd_addr[1] = 5'd7;
    apply_stimulus();
    check_output("t2_fwd0", bus.rd_data[31:0], 64'hDEADBEEF);
    check_output("t2_fwd1", bus.rd_data[63:32], 64'hDEADBEEF);
    clear_stimulus();
    apply_stimulus();
    s_rd_en = 2'b01; s_rd_addr[0] = 5'd7; s_rd_addr[1] = 5'd0;
    apply_stimulus();
    check_output("t2_late", bus.rd_data[31:0], 64'hDEADBEEF);

    $display("[TB] write conflict");
    clear_stimulus();
    s_wr_en = 2'b11; s_wr_addr[0] = 5'd9; s_wr_data[0] = 32'h11;
    s_wr_addr[1] = 5'd9; s_wr_data[1] = 32'h22;
    s_rd_en = 2'b01; s_rd_addr[0] = 5'd9;
    apply_stimulus();
    check_output("t3_rd", bus.rd_data[31:0], 64'h22);
    check_output("t3_arr", bus.dbg_regs[9*XLEN +: XLEN], 64'h22);

    $display("[TB] x0 protection");
    clear_stimulus();
    s_wr_en = 2'b01; s_wr_addr[0] = 5'd0; s_wr_data[0] = 32'hFFFF;
    s_rsv_en = 1'b1; s_rsv_addr = 5'd0;
    s_rd_en = 2'b01; s_rd_addr[0] = 5'd0;
    apply_stimulus();
    check_output("t4_rd", bus.rd_data[31:0], 64'd0);
    check_output("t4_busy0", bus.busy[0], 64'd0);
    check_output("t4_rdbusy", bus.rd_busy[0], 64'd0);

    $display("[TB] scoreboard");
    clear_stimulus();
    s_rsv_en = 1'b1; s_rsv_addr = 5'd4;
    apply_stimulus();
    clear_stimulus();
    s_rd_en = 2'b01; s_rd_addr[0] = 5'd4;
    apply_stimulus();
    check_output("t5_rdbusy", bus.rd_busy[0], 64'd1);
    clear_stimulus();
    s_wr_en = 2'b01; s_wr_addr[0] = 5'd4; s_wr_data[0] = 32'hA5;
    s_rsv_en = 1'b1; s_rsv_addr = 5'd4;
    apply_stimulus();
    check_output("t5_keep", bus.busy[4], 64'd1);
    clear_stimulus();
    s_wr_en = 2'b10; s_wr_addr[1] = 5'd4; s_wr_data[1] = 32'h5A5A;
    s_rd_en = 2'b01; s_rd_addr[0] = 5'd4;
    apply_stimulus();
    check_output("t5_clr", bus.busy[4], 64'd0);
    check_output("t5_rdbusy0", bus.rd_busy[0], 64'd0);
    check_output("t5_fwd", bus.rd_data[31:0], 64'h5A5A);

    $display("[TB] mid-operation reset");
    clear_stimulus();
    s_rst = 1'b1;
    s_wr_en = 2'b01; s_wr_addr[0] = 5'd3; s_wr_data[0] = 32'h55;
    s_rsv_en = 1'b1; s_rsv_addr = 5'd3;
    s_rd_en = 2'b01; s_rd_addr[0] = 5'd3;
    apply_stimulus();
    check_output("t6_x3", bus.dbg_regs[3*XLEN +: XLEN], 64'd0);
    check_output("t6_busy3", bus.busy[3], 64'd0);
    check_output("t6_rd", bus.rd_data[31:0], 64'd0);
    clear_stimulus();
    s_wr_en = 2'b01; s_wr_addr[0] = 5'd3; s_wr_data[0] = 32'h77;
    apply_stimulus();
    check_output("t6_hold", bus.rd_data[31:0], 64'd0);

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      s_rst = ($urandom_range(0, 63) == 0);
      s_rd_en = 2'($urandom);
      s_wr_en = 2'($urandom);
      s_rsv_en = 1'($urandom);
      s_rsv_addr = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      for (int k = 0; k < NRD; k++)
        s_rd_addr[k] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      for (int w = 0; w < NWR; w++) begin
        s_wr_addr[w] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
        s_wr_data[w] = $urandom;
      end
      apply_stimulus();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the pipelined core: the successor to the single-write/dual-read register bank. It supports a configurable number of registers, data width, and read and write ports. It adds a per-register busy scoreboard (reserved at issue, cleared at write-back) so the issue stage can detect pending producers. Reads are registered with write-to-read forwarding. Register 0 is hardwired to zero, and the stack pointer has a configurable reset value.

## Interface
- XLEN, 32, data width in bits
- NREG, 32, number of architectural registers; power of two, ≥4; AW = $clog2(NREG)
- NRD, 2, number of read ports, 1..4
- NWR, 2, number of write ports, 1..3
- SP_IDX, 2, index of the stack-pointer register
- SP_INIT, 32'd512, reset value of register SP_IDX

- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset; it takes effect only at a rising edge of clk
- rd_en  in  NRD  per-port read enable
- rd_addr  in  NRD*AW  read addresses; port k occupies bits [k*AW +: AW]
- rd_data  out  NRD*XLEN  registered read data; port k occupies bits [k*XLEN +: XLEN]
- rd_busy  out  NRD  registered busy flag of the register read on each port
- wr_en  in  NWR  per-port write enable
- wr_addr  in  NWR*AW  write addresses
- wr_data  in  NWR*XLEN  write data
- rsv_en  in  1  reserve request: marks rsv_addr as having a pending producer
- rsv_addr  in  AW  register to reserve
- busy  out  NREG  current scoreboard state, one bit per register
- dbg_regs  out  NREG*XLEN  flat view of the register array for the debug/UART dump

## Operation
- **Reset (rst=1 at an edge)**
  - All registers are set to 0, except register SP_IDX, which is set to SP_INIT.
  - busy, rd_data and rd_busy are all set to 0.
  - Reset overrides every other input in the same cycle.
- **Register 0**
  - Reads always return 0 and register 0 is never busy.
  - Writes and reserves that target address 0 are ignored.
- **Write**
  - Each port w with wr_en[w]=1 and a nonzero address updates its register at the edge.
  - If two or more ports target the same address, the highest-indexed port wins.
- **Read**
  - If rd_en[k]=1, rd_data[k] is loaded at the edge.
    - If an enabled write port targets the same nonzero address in that cycle, the data is the forwarded write data, taken from the winning (highest-indexed) port.
    - Otherwise the data is the array contents.
  - If rd_en[k]=0, rd_data[k] and rd_busy[k] hold their previous values.
- **Scoreboard**
  - rsv_en=1 sets busy[rsv_addr] at the edge.
  - Any enabled write to address a clears busy[a] at the edge.
  - If a reserve and a write target the same address in the same cycle, the reserve wins and busy stays 1. This models a new producer being issued as the old one retires.
- **rd_busy[k]**
  - It is loaded from the busy bit of rd_addr[k], after applying any same-cycle write clear.
  - A same-cycle reserve is not reflected in rd_busy[k]. The reserving instruction is younger than the reader.
- **dbg_regs**
  - Combinational view of the array state, with no forwarding.
  - A write becomes visible in the cycle after its edge.

## Timing
- Read latency is 1 cycle: the address is presented in cycle n and rd_data is valid after edge n and through cycle n+1.
- Write latency is 1 cycle to the array. A read in the same cycle as the write sees the new value through forwarding, with no bubble.
- Scoreboard updates take effect at the edge. busy reflects the new state in the following cycle.
- There are no combinational paths from any input to any output, except the array-to-dbg_regs and busy-state-to-busy views.
- Reset mid-operation:
  - Writes, reserves and reads in the reset cycle are discarded.
  - The first operations that take effect are those presented in the cycle after reset deasserts.
- Writes and reads on all ports are supported concurrently every cycle. There is no stall or backpressure.

## Test plan
1. **Reset values:** assert rst for 1 cycle, then read registers 2 and 5 on ports 0 and 1 → rd_data = 512 and 0; busy = 0; dbg_regs slot 2 = 512.
2. **Forwarding:** in one cycle, write 0xDEADBEEF to x7 on port 0 while reading x7 on ports 0 and 1 → both rd_data = 0xDEADBEEF next cycle. A read of x7 two cycles later also returns 0xDEADBEEF.
3. **Write conflict:** in one cycle, port 0 writes x9=0x11 and port 1 writes x9=0x22, with a same-cycle read of x9 → rd_data = 0x22 and array x9 = 0x22.
4. **x0 protection:** write 0xFFFF to x0 and reserve x0, then read x0 → rd_data = 0, busy[0] = 0, rd_busy = 0.
5. **Scoreboard:**
   - Reserve x4, then read x4 next cycle → rd_busy = 1.
   - Write x4 and reserve x4 in the same cycle → busy[4] stays 1.
   - Write x4 alone → busy[4] = 0, and a same-cycle read of x4 gives rd_busy = 0 with the forwarded data.
6. **Mid-operation reset:** write x3=0x55 and reserve x3 in the same cycle as rst=1 → x3 = 0, busy[3] = 0, rd_data = 0. With rd_en=0 afterwards, rd_data holds 0.
